transceive: RTL and testbench
=============================

# transceive

Byte-wide UART transceiver: an 8N1 serial receiver and transmitter sharing one clock, reset and baud configuration. It sits between the board serial pins and the on-chip byte-stream fabric. Received bytes leave on a strobe/ready stream; bytes to send enter on a strobe/ready stream.

## Interface
- `BAUD`, default 9600: serial bit rate in bits/s.
- `FREQ`, default 12e6: `clk` frequency in Hz.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `rxd`  in  1  serial input; asynchronous to `clk`; idle high.
- `txd`  out  1  serial output; idle high.
- `rx_dat`  out  8  received byte.
- `rx_stb`  out  1  `rx_dat` valid.
- `rx_rdy`  in  1  consumer accepts `rx_dat`.
- `rx_err`  out  1  error flag for the last frame.
- `tx_dat`  in  8  byte to send.
- `tx_stb`  in  1  `tx_dat` valid.
- `tx_rdy`  out  1  transmitter can accept a byte.

## Operation
- Frame format:
  - one start bit (0);
  - 8 data bits, LSB first;
  - one stop bit (1);
  - no parity.
- Bit period: `DIV = round(FREQ/BAUD)` clocks, which is 1250 at the defaults. Counter width is `$clog2(DIV)`.
- Receiver:
  - `rxd` passes through a 2-flop synchronizer.
  - IDLE: on a synchronized 1→0 transition, go to START.
  - START: wait `DIV/2`, then sample. If the sample is 0, go to DATA. If it is 1 (glitch), return to IDLE and emit nothing.
  - DATA: sample every `DIV` clocks and shift into bit 0..7.
  - STOP: sample after a further `DIV` clocks.
  - Good stop bit (1): load `rx_dat`, assert `rx_stb`, clear `rx_err`, go to IDLE.
  - Bad stop bit (0): framing error. Load `rx_dat`, assert `rx_stb`, set `rx_err`. Wait for `rxd` to return to 1, then go to IDLE.
  - `rx_stb` stays high until a cycle with `rx_stb && rx_rdy`, then drops on the next clock.
  - Overrun (a new frame completes while `rx_stb` is still high): `rx_dat` is overwritten, `rx_stb` stays high, `rx_err` is set.
  - `rx_err` holds its value until the next completed frame or reset.
- Transmitter:
  - IDLE: `tx_rdy` = 1. A cycle with `tx_stb && tx_rdy` latches `tx_dat` and drops `tx_rdy` on the next clock.
  - Sequence: START (0), DATA bits 0..7, STOP (1), each held for `DIV` clocks, then IDLE.
  - `tx_dat` and `tx_stb` are ignored while `tx_rdy` = 0.
- The receiver and transmitter are fully independent. Simultaneous receive and transmit is required.

## Timing
- Reset values: `txd`=1, `tx_rdy`=1, `rx_stb`=0, `rx_err`=0, `rx_dat`=0. Both state machines are in IDLE.
- Reset mid-frame aborts both machines immediately. Outputs take their reset values and the partial byte is discarded.
- Transmit latency: `txd` falls on the clock after the accepting handshake. The frame lasts `10*DIV` clocks. `tx_rdy` rises on the clock after the stop bit's last cycle.
- Back-to-back transmit: a byte may be accepted in the first cycle `tx_rdy`=1. The next start bit follows with no idle gap.
- Receive latency: `rx_stb` rises 2–3 clocks (synchronizer) after mid-stop-bit, i.e. about `9.5*DIV` clocks after the start edge.
- The receiver re-arms at mid-stop-bit. It must accept a start edge arriving immediately after the stop bit.
- Tolerance: bytes must be received correctly with up to ±2% baud mismatch.

## Configuration
- `TRANSCEIVE_LOOPBACK_EN` defined:
  - the receive stream is connected internally to the transmit stream (`rx_dat`→tx data, `rx_stb`→tx strobe, `tx_rdy`→rx ready);
  - external `tx_stb`/`tx_dat` and `rx_rdy` are ignored;
  - `rx_stb` and `rx_dat` remain observable;
  - every received byte is echoed on `txd`.
- Undefined: the two streams are independent, as described above.

## Structure
- Shared package `transceive_pkg`:
  - frame constants: `DATA_BITS`=8, `START_BIT`=0, `STOP_BIT`=1;
  - receiver state enum: IDLE, START, DATA, STOP;
  - transmitter state enum: IDLE, START, DATA, STOP;
  - function computing `DIV` from `FREQ`/`BAUD`.
- One sub-module is natural: `transceive_baud`, a loadable down-counter with `DIV` and `DIV/2` reload and a tick output. It is instantiated once per direction.

## Test plan
- Echo with `TRANSCEIVE_LOOPBACK_EN`, defaults: drive 8 random bytes (e.g. 0xA5, 0x00, 0xFF) on `rxd` while capturing `txd`. Each captured byte equals the sent byte; `rx_err`=0 after each.
- Repeat the echo run after asserting `rst` low for one cycle: same results, `txd`=1 and `tx_rdy`=1 while in reset.
- Frame 0x3C with stop bit driven 0: `rx_stb`=1, `rx_dat`=0x3C, `rx_err`=1. A following good frame 0x55 clears `rx_err` to 0.
- Hold `rx_rdy`=0 and send 0x11 then 0x22: `rx_dat`=0x22, `rx_err`=1 (overrun), `rx_stb` stays high until `rx_rdy`=1.
- Transmit 0x81: `txd` falls 1 clock after the handshake. The bit sequence is 0,1,0,0,0,0,0,0,1,1, each bit `DIV`=1250 clocks. `tx_rdy` is low for exactly 12500 clocks.
- A 0.25-bit low glitch on `rxd`: no `rx_stb`, receiver back in IDLE.

Source files
------------

// File: rtl/transceive_pkg.sv
// transceive_pkg: frame constants, state encodings and bit-period helper
// shared by the UART transceiver and its baud counter.
package transceive_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam logic        START_BIT = 1'b0;
   localparam logic        STOP_BIT  = 1'b1;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   // Clocks per bit, rounded to nearest.
   function automatic int unsigned calc_div(int unsigned freq, int unsigned baud);
      return (freq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/transceive_baud.sv
// transceive_baud: loadable bit-period down-counter. A full load times one
// bit, a half load times the distance from a start edge to mid-bit. tick_o
// is high while the count has expired.
module transceive_baud #(
   parameter int unsigned DIV = 1250
) (
   input  logic clk,
   input  logic rst,
   input  logic load_full_i,
   input  logic load_half_i,
   output logic tick_o
);

   localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: reload on request, otherwise run down and park at zero.
   // NOTE: cnt_d gets a default first so every path assigns it and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load_full_i)       cnt_d = CW'(DIV - 1);
      else if (load_half_i)  cnt_d = CW'(DIV / 2 - 1);
      else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
   end

   // Count register.
   // NOTE: sequential state uses non-blocking assignments; combinational logic uses blocking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/transceive.sv
// transceive: 8N1 UART receiver and transmitter sharing clock, reset and
// baud configuration. Received bytes leave on rx_dat/rx_stb/rx_rdy, bytes to
// send enter on tx_dat/tx_stb/tx_rdy.
// Build option: define TRANSCEIVE_LOOPBACK_EN to echo every received byte on
// txd (external tx_dat/tx_stb and rx_rdy are then ignored).
module transceive
   import transceive_pkg::*;
#(
   parameter int unsigned BAUD = 9600,
   parameter int unsigned FREQ = 12_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic                 txd,
   output logic [DATA_BITS-1:0] rx_dat,
   output logic                 rx_stb,
   input  logic                 rx_rdy,
   output logic                 rx_err,
   input  logic [DATA_BITS-1:0] tx_dat,
   input  logic                 tx_stb,
   output logic                 tx_rdy
);

   localparam int unsigned DIV = calc_div(FREQ, BAUD);

   // Receiver state
   rx_state_e            rx_state_q, rx_state_d;
   logic [1:0]           rx_sync_q;
   logic                 rx_prev_q;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic [2:0]           rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_dat_q, rx_dat_d;
   logic                 rx_stb_q, rx_stb_d;
   logic                 rx_err_q, rx_err_d;
   logic                 rx_load_full, rx_load_half, rx_tick;
   logic                 rx_s;

   // Transmitter state
   tx_state_e            tx_state_q, tx_state_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic [2:0]           tx_bit_q, tx_bit_d;
   logic                 txd_q, txd_d;
   logic                 tx_load_full, tx_tick;

   // Stream sources after the loopback selection
   logic [DATA_BITS-1:0] tx_dat_w;
   logic                 tx_stb_w;
   logic                 rx_rdy_w;
   logic                 tx_rdy_w;

   assign tx_rdy_w = (tx_state_q == TX_IDLE);

`ifdef TRANSCEIVE_LOOPBACK_EN
   logic unused_ext;
   assign unused_ext = ^{tx_dat, tx_stb, rx_rdy};
   assign tx_dat_w   = rx_dat_q;
   assign tx_stb_w   = rx_stb_q;
   assign rx_rdy_w   = tx_rdy_w;
`else
   assign tx_dat_w   = tx_dat;
   assign tx_stb_w   = tx_stb;
   assign rx_rdy_w   = rx_rdy;
`endif

   transceive_baud #(.DIV(DIV)) u_rx_baud (
      .clk         (clk),
      .rst         (rst),
      .load_full_i (rx_load_full),
      .load_half_i (rx_load_half),
      .tick_o      (rx_tick)
   );

   transceive_baud #(.DIV(DIV)) u_tx_baud (
      .clk         (clk),
      .rst         (rst),
      .load_full_i (tx_load_full),
      .load_half_i (1'b0),
      .tick_o      (tx_tick)
   );

   assign rx_s = rx_sync_q[1];

   // Synchronize rxd and keep the previous synchronized level for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_sync_q <= 2'b11;
         rx_prev_q <= 1'b1;
      end else begin
         rx_sync_q <= {rx_sync_q[0], rxd};
         rx_prev_q <= rx_s;
      end
   end

   // Receiver next state: find start edge, verify at mid-start, sample each
   // mid-bit, and deliver at mid-stop. After a bad stop bit the line is low,
   // so no new 1->0 edge is seen until it has returned high.
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_shift_d   = rx_shift_q;
      rx_bit_d     = rx_bit_q;
      rx_dat_d     = rx_dat_q;
      rx_stb_d     = rx_stb_q;
      rx_err_d     = rx_err_q;
      rx_load_full = 1'b0;
      rx_load_half = 1'b0;
      if (rx_stb_q && rx_rdy_w) rx_stb_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_s) begin
               rx_state_d   = RX_START;
               rx_load_half = 1'b1;
            end
         end
         RX_START: begin
            if (rx_tick) begin
               if (rx_s == START_BIT) begin
                  rx_state_d   = RX_DATA;
                  rx_bit_d     = '0;
                  rx_load_full = 1'b1;
               end else begin
                  rx_state_d   = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            if (rx_tick) begin
               rx_shift_d   = {rx_s, rx_shift_q[DATA_BITS-1:1]};
               rx_load_full = 1'b1;
               if (rx_bit_q == 3'(DATA_BITS - 1)) rx_state_d = RX_STOP;
               else                               rx_bit_d   = rx_bit_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (rx_tick) begin
               rx_dat_d   = rx_shift_q;
               rx_stb_d   = 1'b1;
               rx_err_d   = (rx_s != STOP_BIT) || (rx_stb_q && !rx_rdy_w);
               rx_state_d = RX_IDLE;
            end
         end
      endcase
   end

   // Receiver registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_q <= RX_IDLE;
         rx_shift_q <= '0;
         rx_bit_q   <= '0;
         rx_dat_q   <= '0;
         rx_stb_q   <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_shift_q <= rx_shift_d;
         rx_bit_q   <= rx_bit_d;
         rx_dat_q   <= rx_dat_d;
         rx_stb_q   <= rx_stb_d;
         rx_err_q   <= rx_err_d;
      end
   end

   // Transmitter next state: accept in IDLE, then shift start, data, stop,
   // each held for one bit period.
   always_comb begin
      tx_state_d   = tx_state_q;
      tx_shift_d   = tx_shift_q;
      tx_bit_d     = tx_bit_q;
      txd_d        = txd_q;
      tx_load_full = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (tx_stb_w) begin
               tx_shift_d   = tx_dat_w;
               txd_d        = START_BIT;
               tx_state_d   = TX_START;
               tx_load_full = 1'b1;
            end
         end
         TX_START: begin
            if (tx_tick) begin
               txd_d        = tx_shift_q[0];
               tx_shift_d   = tx_shift_q >> 1;
               tx_bit_d     = '0;
               tx_state_d   = TX_DATA;
               tx_load_full = 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_tick) begin
               tx_load_full = 1'b1;
               if (tx_bit_q == 3'(DATA_BITS - 1)) begin
                  txd_d      = STOP_BIT;
                  tx_state_d = TX_STOP;
               end else begin
                  txd_d      = tx_shift_q[0];
                  tx_shift_d = tx_shift_q >> 1;
                  tx_bit_d   = tx_bit_q + 3'd1;
               end
            end
         end
         TX_STOP: begin
            if (tx_tick) tx_state_d = TX_IDLE;
         end
      endcase
   end

   // Transmitter registers; txd is registered so it is glitch-free at the pin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q <= TX_IDLE;
         tx_shift_q <= '0;
         tx_bit_q   <= '0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_bit_q   <= tx_bit_d;
         txd_q      <= txd_d;
      end
   end

   assign txd    = txd_q;
   assign tx_rdy = tx_rdy_w;
   assign rx_dat = rx_dat_q;
   assign rx_stb = rx_stb_q;
   assign rx_err = rx_err_q;

endmodule

// File: tb/tb_transceive.sv
// tb_transceive: directed self-checking bench for the UART transceiver.
// Runs with a short bit period (DIV = 32 clocks) to keep runtime small.
module tb_transceive;

   localparam int unsigned FREQ   = 3_200_000;
   localparam int unsigned BAUD   = 100_000;
   localparam int          DIV    = 32;
   localparam int          BIT_NS = DIV * 10;

   logic       clk    = 1'b0;
   logic       rst    = 1'b0;
   logic       rxd    = 1'b1;
   logic       rx_rdy = 1'b0;
   logic       tx_stb = 1'b0;
   logic [7:0] tx_dat = 8'h00;
   logic       txd, rx_stb, rx_err, tx_rdy;
   logic [7:0] rx_dat;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   transceive #(.BAUD(BAUD), .FREQ(FREQ)) dut (
      .clk    (clk),
      .rst    (rst),
      .rxd    (rxd),
      .txd    (txd),
      .rx_dat (rx_dat),
      .rx_stb (rx_stb),
      .rx_rdy (rx_rdy),
      .rx_err (rx_err),
      .tx_dat (tx_dat),
      .tx_stb (tx_stb),
      .tx_rdy (tx_rdy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Drive one 8N1 frame on rxd with the given bit time in ns.
   task automatic send_rx(input logic [7:0] b, input logic stop, input int bit_ns);
      rxd = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         #(bit_ns);
      end
      rxd = stop;
      #(bit_ns);
      rxd = 1'b1;
   endtask

   // Decode one frame from txd by mid-bit sampling; t0 is the cycle of the start edge.
   task automatic capture_tx(output logic [7:0] b, output bit framed, output int t0);
      int n = 0;
      while (txd !== 1'b0 && n < 24 * DIV) begin
         @(negedge clk);
         n++;
      end
      t0     = cyc;
      b      = 8'h00;
      framed = 1'b0;
      if (txd === 1'b0) begin
         repeat (DIV / 2) @(negedge clk);
         framed = (txd === 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = txd;
         end
         repeat (DIV) @(negedge clk);
         framed = framed && (txd === 1'b1);
      end
   endtask

   task automatic wait_rx_stb(output bit ok);
      int n = 0;
      while (rx_stb !== 1'b1 && n < 4 * DIV) begin
         @(negedge clk);
         n++;
      end
      ok = (rx_stb === 1'b1);
   endtask

   task automatic ack_rx();
      @(negedge clk);
      rx_rdy = 1'b1;
      @(negedge clk);
      rx_rdy = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++; if (txd !== 1'b1)    begin miscompares++; $display("FAIL reset_txd: got %b want 1", txd); end
      vectors++; if (tx_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_tx_rdy: got %b want 1", tx_rdy); end
      vectors++; if (rx_stb !== 1'b0) begin miscompares++; $display("FAIL reset_rx_stb: got %b want 0", rx_stb); end
      vectors++; if (rx_err !== 1'b0) begin miscompares++; $display("FAIL reset_rx_err: got %b want 0", rx_err); end
      vectors++; if (rx_dat !== 8'h00) begin miscompares++; $display("FAIL reset_rx_dat: got %h want 00", rx_dat); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

`ifdef TRANSCEIVE_LOOPBACK_EN
   task automatic test_echo();
      logic [7:0] pat [8] = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h81, 8'h5A, 8'hC3, 8'h7E};
      logic [7:0] cap;
      bit         framed;
      int         t0;
      foreach (pat[i]) begin
         fork
            send_rx(pat[i], 1'b1, BIT_NS);
            capture_tx(cap, framed, t0);
         join
         vectors++; if (cap !== pat[i]) begin miscompares++; $display("FAIL echo_byte[%0d]: got %h want %h", i, cap, pat[i]); end
         vectors++; if (!framed) begin miscompares++; $display("FAIL echo_frame[%0d]: got bad start/stop want good", i); end
         vectors++; if (rx_err !== 1'b0) begin miscompares++; $display("FAIL echo_err[%0d]: got %b want 0", i, rx_err); end
         repeat (2) @(negedge clk);
      end
      repeat (4 * DIV) @(negedge clk);
   endtask

   task automatic test_loopback_reset();
      send_rx(8'h77, 1'b1, BIT_NS);
      repeat (DIV) @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++; if (txd !== 1'b1)    begin miscompares++; $display("FAIL lb_reset_txd: got %b want 1", txd); end
      vectors++; if (tx_rdy !== 1'b1) begin miscompares++; $display("FAIL lb_reset_tx_rdy: got %b want 1", tx_rdy); end
      @(negedge clk);
      rst = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL lb_reset_abort: txd got %b want 1", txd); end
   endtask
`else
   task automatic test_tx_single();
      int exp_bits [10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
      int k = 0;
      @(negedge clk);
      vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL tx_idle_level: got %b want 1", txd); end
      tx_dat = 8'h81;
      tx_stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_stb = 1'b0;
      vectors++; if (txd !== 1'b0) begin miscompares++; $display("FAIL tx_latency: txd got %b want 0", txd); end
      while (tx_rdy === 1'b0 && k < 12 * DIV) begin
         if (k % DIV == DIV / 2 && k / DIV < 10) begin
            vectors++;
            if (txd !== exp_bits[k / DIV][0]) begin
               miscompares++;
               $display("FAIL tx_bit[%0d]: got %b want %0d", k / DIV, txd, exp_bits[k / DIV]);
            end
         end
         @(negedge clk);
         k++;
      end
      vectors++; if (k != 10 * DIV) begin miscompares++; $display("FAIL tx_rdy_low_cycles: got %0d want %0d", k, 10 * DIV); end
      vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL tx_after_frame: txd got %b want 1", txd); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b1, b2;
      bit         f1, f2;
      int         t1, t2;
      fork
         begin
            int n = 0;
            @(negedge clk);
            tx_dat = 8'h3A;
            tx_stb = 1'b1;
            @(negedge clk);
            tx_dat = 8'hC5;
            while (tx_rdy !== 1'b1 && n < 12 * DIV) begin
               @(negedge clk);
               n++;
            end
            @(negedge clk);
            tx_stb = 1'b0;
         end
         begin
            capture_tx(b1, f1, t1);
            capture_tx(b2, f2, t2);
         end
      join
      vectors++; if (b1 !== 8'h3A) begin miscompares++; $display("FAIL b2b_first: got %h want 3a", b1); end
      vectors++; if (b2 !== 8'hC5) begin miscompares++; $display("FAIL b2b_second: got %h want c5", b2); end
      vectors++; if (!(f1 && f2)) begin miscompares++; $display("FAIL b2b_framing: got %b%b want 11", f1, f2); end
      vectors++; if (t2 - t1 != 10 * DIV + 1) begin miscompares++; $display("FAIL b2b_spacing: got %0d want %0d", t2 - t1, 10 * DIV + 1); end
      repeat (DIV) @(negedge clk);
   endtask

   task automatic test_rx_basic();
      logic [7:0] pat [3] = '{8'hA5, 8'h00, 8'hFF};
      bit         ok;
      foreach (pat[i]) begin
         send_rx(pat[i], 1'b1, BIT_NS);
         wait_rx_stb(ok);
         vectors++; if (!ok) begin miscompares++; $display("FAIL rx_stb[%0d]: got 0 want 1", i); end
         vectors++; if (rx_dat !== pat[i]) begin miscompares++; $display("FAIL rx_dat[%0d]: got %h want %h", i, rx_dat, pat[i]); end
         vectors++; if (rx_err !== 1'b0) begin miscompares++; $display("FAIL rx_err[%0d]: got %b want 0", i, rx_err); end
         ack_rx();
         vectors++; if (rx_stb !== 1'b0) begin miscompares++; $display("FAIL rx_ack[%0d]: rx_stb got %b want 0", i, rx_stb); end
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_framing();
      bit ok;
      send_rx(8'h3C, 1'b0, BIT_NS);
      wait_rx_stb(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL frame_stb: got 0 want 1"); end
      vectors++; if (rx_dat !== 8'h3C) begin miscompares++; $display("FAIL frame_dat: got %h want 3c", rx_dat); end
      vectors++; if (rx_err !== 1'b1) begin miscompares++; $display("FAIL frame_err: got %b want 1", rx_err); end
      ack_rx();
      repeat (2) @(negedge clk);
      send_rx(8'h55, 1'b1, BIT_NS);
      wait_rx_stb(ok);
      vectors++; if (rx_dat !== 8'h55) begin miscompares++; $display("FAIL frame_next_dat: got %h want 55", rx_dat); end
      vectors++; if (rx_err !== 1'b0) begin miscompares++; $display("FAIL frame_next_err: got %b want 0", rx_err); end
      ack_rx();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_overrun();
      bit ok;
      rx_rdy = 1'b0;
      send_rx(8'h11, 1'b1, BIT_NS);
      send_rx(8'h22, 1'b1, BIT_NS);
      wait_rx_stb(ok);
      vectors++; if (rx_dat !== 8'h22) begin miscompares++; $display("FAIL overrun_dat: got %h want 22", rx_dat); end
      vectors++; if (rx_err !== 1'b1) begin miscompares++; $display("FAIL overrun_err: got %b want 1", rx_err); end
      repeat (3 * DIV) @(negedge clk);
      vectors++; if (rx_stb !== 1'b1) begin miscompares++; $display("FAIL overrun_hold: rx_stb got %b want 1", rx_stb); end
      ack_rx();
      vectors++; if (rx_stb !== 1'b0) begin miscompares++; $display("FAIL overrun_ack: rx_stb got %b want 0", rx_stb); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_glitch();
      bit ok;
      @(negedge clk);
      rxd = 1'b0;
      repeat (DIV / 4) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      vectors++; if (rx_stb !== 1'b0) begin miscompares++; $display("FAIL glitch_stb: got %b want 0", rx_stb); end
      send_rx(8'hC3, 1'b1, BIT_NS);
      wait_rx_stb(ok);
      vectors++; if (rx_dat !== 8'hC3) begin miscompares++; $display("FAIL glitch_next_dat: got %h want c3", rx_dat); end
      ack_rx();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_tolerance();
      bit ok;
      send_rx(8'h6D, 1'b1, BIT_NS * 102 / 100);
      wait_rx_stb(ok);
      vectors++; if (rx_dat !== 8'h6D) begin miscompares++; $display("FAIL tol_slow_dat: got %h want 6d", rx_dat); end
      vectors++; if (rx_err !== 1'b0) begin miscompares++; $display("FAIL tol_slow_err: got %b want 0", rx_err); end
      ack_rx();
      repeat (2) @(negedge clk);
      send_rx(8'hB2, 1'b1, BIT_NS * 98 / 100);
      wait_rx_stb(ok);
      vectors++; if (rx_dat !== 8'hB2) begin miscompares++; $display("FAIL tol_fast_dat: got %h want b2", rx_dat); end
      vectors++; if (rx_err !== 1'b0) begin miscompares++; $display("FAIL tol_fast_err: got %b want 0", rx_err); end
      ack_rx();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_simultaneous();
      logic [7:0] cap;
      bit         framed, ok;
      int         t0;
      fork
         send_rx(8'h96, 1'b1, BIT_NS);
         begin
            @(negedge clk);
            tx_dat = 8'h69;
            tx_stb = 1'b1;
            @(negedge clk);
            tx_stb = 1'b0;
         end
         capture_tx(cap, framed, t0);
      join
      wait_rx_stb(ok);
      vectors++; if (cap !== 8'h69) begin miscompares++; $display("FAIL simul_tx: got %h want 69", cap); end
      vectors++; if (rx_dat !== 8'h96) begin miscompares++; $display("FAIL simul_rx: got %h want 96", rx_dat); end
      ack_rx();
      repeat (DIV) @(negedge clk);
   endtask

   task automatic test_reset_midframe();
      fork
         send_rx(8'hF0, 1'b1, BIT_NS);
      join_none
      @(negedge clk);
      tx_dat = 8'h00;
      tx_stb = 1'b1;
      @(negedge clk);
      tx_stb = 1'b0;
      repeat (4 * DIV) @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++; if (txd !== 1'b1)     begin miscompares++; $display("FAIL midrst_txd: got %b want 1", txd); end
      vectors++; if (tx_rdy !== 1'b1)  begin miscompares++; $display("FAIL midrst_tx_rdy: got %b want 1", tx_rdy); end
      vectors++; if (rx_dat !== 8'h00) begin miscompares++; $display("FAIL midrst_rx_dat: got %h want 00", rx_dat); end
      @(negedge clk);
      rst = 1'b1;
      wait fork;
      repeat (2 * DIV) @(negedge clk);
      vectors++; if (rx_stb !== 1'b0) begin miscompares++; $display("FAIL midrst_partial: rx_stb got %b want 0", rx_stb); end
      vectors++; if (txd !== 1'b1)    begin miscompares++; $display("FAIL midrst_tx_abort: txd got %b want 1", txd); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef TRANSCEIVE_LOOPBACK_EN
      test_echo();
      test_loopback_reset();
      test_echo();
`else
      test_tx_single();
      test_back_to_back();
      test_rx_basic();
      test_framing();
      test_overrun();
      test_glitch();
      test_tolerance();
      test_simultaneous();
      test_reset_midframe();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
